// File: rtl/mac_sequencer.sv
// Operand sequencer and frame accumulator wrapped around a fixed-latency multiplier.
// Issues one operand pair at a time, accumulates the products, and reports each frame's sum and count.
module mac_sequencer #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned ACC_W       = 24,
   parameter int unsigned MUL_LATENCY = 10,
   parameter int unsigned COUNT_W     = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [WIDTH-1:0]     op_A,
   input  logic [WIDTH-1:0]     op_B,
   input  logic                 op_last,
   input  logic                 clear,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_A,
   output logic [WIDTH-1:0]     mul_B,
   input  logic [2*WIDTH-1:0]   mul_pp,
   output logic [ACC_W-1:0]     acc_out,
   output logic [COUNT_W-1:0]   count_out,
   output logic                 acc_valid,
   output logic                 overflow
);

   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned WAIT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MUL_LATENCY - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [ACC_W-1:0]    acc;
   logic [COUNT_W-1:0]  count;
   logic                ovf_acc;
   logic                last;
   logic [SUM_W-1:0]    sum_c;
   logic [COUNT_W-1:0]  count_inc_c;

   // Extra top bit of the sum is the accumulator carry-out.
   assign sum_c       = {1'b0, acc} + SUM_W'(mul_pp);
   assign count_inc_c = count + COUNT_W'(1);

   // Next-state logic; clear overrides every transition, including a handshake.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (op_valid && op_ready) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (wait_cnt == '0) state_nx = S_ACCUM;
         S_ACCUM: state_nx = last ? S_DONE : S_IDLE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (clear) state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         op_ready  <= 1'b0;
         mul_start <= 1'b0;
         acc_valid <= 1'b0;
         mul_A     <= '0;
         mul_B     <= '0;
         last      <= 1'b0;
         wait_cnt  <= '0;
         acc       <= '0;
         count     <= '0;
         ovf_acc   <= 1'b0;
         acc_out   <= '0;
         count_out <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nx;
         op_ready  <= (state_nx == S_IDLE);
         mul_start <= (state_nx == S_ISSUE);
         acc_valid <= (state_nx == S_DONE);
         if (clear) begin
            acc     <= '0;
            count   <= '0;
            ovf_acc <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (op_valid && op_ready) begin
                     mul_A <= op_A;
                     mul_B <= op_B;
                     last  <= op_last;
                  end
               end
               S_ISSUE: wait_cnt <= WAIT_LOAD;
               S_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
               S_ACCUM: begin
                  acc     <= sum_c[ACC_W-1:0];
                  count   <= count_inc_c;
                  ovf_acc <= ovf_acc | sum_c[ACC_W];
                  // Results land with the DONE entry so they coincide with acc_valid.
                  if (last) begin
                     acc_out   <= sum_c[ACC_W-1:0];
                     count_out <= count_inc_c;
                     overflow  <= ovf_acc | sum_c[ACC_W];
                  end
               end
               S_DONE: begin
                  acc     <= '0;
                  count   <= '0;
                  ovf_acc <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: multiplier stub, pair-level reference model checked every cycle,
// and directed frames with hand-computed results.
module tb_mac_sequencer;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned ACC_W   = 24;
   localparam int unsigned L       = 10;
   localparam int unsigned COUNT_W = 10;
   localparam longint      ACC_MOD = longint'(1) << ACC_W;

   logic                clk = 1'b0;
   logic                reset;
   logic                op_valid;
   logic                op_ready;
   logic [WIDTH-1:0]    op_A;
   logic [WIDTH-1:0]    op_B;
   logic                op_last;
   logic                clear;
   logic                mul_start;
   logic [WIDTH-1:0]    mul_A;
   logic [WIDTH-1:0]    mul_B;
   logic [2*WIDTH-1:0]  mul_pp;
   logic [ACC_W-1:0]    acc_out;
   logic [COUNT_W-1:0]  count_out;
   logic                acc_valid;
   logic                overflow;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int scount = 0;
   int vcount = 0;
   int start_cyc = 0;
   int valid_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_sequencer #(
      .WIDTH(WIDTH), .ACC_W(ACC_W), .MUL_LATENCY(L), .COUNT_W(COUNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready), .op_A(op_A), .op_B(op_B),
      .op_last(op_last), .clear(clear),
      .mul_start(mul_start), .mul_A(mul_A), .mul_B(mul_B), .mul_pp(mul_pp),
      .acc_out(acc_out), .count_out(count_out), .acc_valid(acc_valid),
      .overflow(overflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // Multiplier stub: product shows up only in the cycle L after mul_start, garbage otherwise.
   int              pp_cycle = -1;
   logic [15:0]     pp_val = '0;
   initial forever begin
      @(negedge clk);
      mul_pp = (cyc == pp_cycle) ? pp_val : 16'hDEAD;
      if (mul_start) begin
         pp_cycle = cyc + L;
         pp_val   = 16'(mul_A) * 16'(mul_B);
      end
   end

   // Reference model at pair/frame level: expected outputs for the cycle starting at each edge.
   logic   m_idle, m_done, m_ready, m_start, m_valid, m_last, m_ovf, m_oflag;
   logic [WIDTH-1:0] m_a, m_b;
   longint m_acc, m_out, m_prod;
   int     m_cnt, m_cout, m_accum_at;
   initial forever begin
      int n;
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_idle = 1'b1; m_done = 1'b0; m_ready = 1'b0; m_start = 1'b0; m_valid = 1'b0;
         m_last = 1'b0; m_ovf = 1'b0; m_oflag = 1'b0; m_a = '0; m_b = '0;
         m_acc = 0; m_out = 0; m_prod = 0; m_cnt = 0; m_cout = 0; m_accum_at = -1;
      end else begin
         n = cyc + 1;
         m_start = 1'b0;
         m_valid = 1'b0;
         if (clear) begin
            m_idle = 1'b1; m_done = 1'b0; m_ready = 1'b1;
            m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
         end else if (m_idle) begin
            if (op_valid && m_ready) begin
               m_a = op_A; m_b = op_B; m_last = op_last;
               m_prod = longint'(op_A) * longint'(op_B);
               m_idle = 1'b0; m_ready = 1'b0; m_start = 1'b1;
               m_accum_at = n + L + 1;
            end else begin
               m_ready = 1'b1;
            end
         end else if (m_done) begin
            m_done = 1'b0; m_idle = 1'b1; m_ready = 1'b1;
         end else if (n == m_accum_at) begin
            m_acc = m_acc + m_prod;
            if (m_acc >= ACC_MOD) begin
               m_ovf = 1'b1;
               m_acc = m_acc - ACC_MOD;
            end
            m_cnt = (m_cnt + 1) % (1 << COUNT_W);
            if (m_last) begin
               m_out = m_acc; m_cout = m_cnt; m_oflag = m_ovf; m_valid = 1'b1;
               m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_done = 1'b1;
            end else begin
               m_idle = 1'b1; m_ready = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         chk("op_ready", op_ready, m_ready);
         chk("mul_start", mul_start, m_start);
         chk("acc_valid", acc_valid, m_valid);
         chk("mul_A", mul_A, m_a);
         chk("mul_B", mul_B, m_b);
         chk("acc_out", acc_out, m_out[ACC_W-1:0]);
         chk("count_out", count_out, m_cout[COUNT_W-1:0]);
         chk("overflow", overflow, m_oflag);
      end
      if (mul_start) begin scount++; start_cyc = cyc; end
      if (acc_valid) begin vcount++; valid_cyc = cyc; end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic lst);
      int t = 0;
      @(negedge clk);
      op_valid = 1'b1; op_A = a; op_B = b; op_last = lst;
      while (!op_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("send_ready", op_ready, 1);
      @(negedge clk);
      op_valid = 1'b0; op_A = 8'($urandom); op_B = 8'($urandom); op_last = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [23:0] ea, input logic [9:0] ec,
                              input logic eo);
      int t = 0;
      @(negedge clk);
      while (!acc_valid && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_seen"}, acc_valid, 1);
      chk({tag, "_acc"}, acc_out, ea);
      chk({tag, "_cnt"}, count_out, ec);
      chk({tag, "_ovf"}, overflow, eo);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, v0;
      reset = 1'b0; op_valid = 1'b0; op_A = '0; op_B = '0; op_last = 1'b0; clear = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", op_ready, 1);
      chk("rst_acc", acc_out, 0);

      // Single-pair frame
      s0 = scount; v0 = vcount;
      send(8'h0A, 8'h20, 1'b1);
      wait_result("single", 24'h000140, 10'd1, 1'b0);
      @(negedge clk);
      chk("single_starts", scount - s0, 1);
      chk("single_valids", vcount - v0, 1);
      chk("single_latency", valid_cyc - start_cyc, L + 1);

      // Three-pair frame
      v0 = vcount;
      send(8'h0A, 8'h20, 1'b0);
      send(8'hFF, 8'hFF, 1'b0);
      send(8'h03, 8'h05, 1'b1);
      wait_result("three", 24'h00FF50, 10'd3, 1'b0);
      @(negedge clk);
      chk("three_valids", vcount - v0, 1);

      // Handshake stall: changing pair held while busy
      send(8'h11, 8'h22, 1'b0);
      repeat (5) begin
         @(negedge clk);
         op_valid = 1'b1; op_A = 8'($urandom); op_B = 8'($urandom); op_last = 1'($urandom);
      end
      chk("stall_mulA", mul_A, 8'h11);
      chk("stall_mulB", mul_B, 8'h22);
      chk("stall_ready", op_ready, 0);
      send(8'h04, 8'h05, 1'b1);
      wait_result("stall", 24'h000256, 10'd2, 1'b0);

      // Overflow frame, then a clean frame
      for (int i = 0; i < 259; i++) send(8'hFF, 8'hFF, i == 258);
      wait_result("ovf", 24'h00FB03, 10'd259, 1'b1);
      send(8'h01, 8'h01, 1'b1);
      wait_result("ovf_next", 24'h000001, 10'd1, 1'b0);

      // clear during WAIT of the second pair
      v0 = vcount;
      send(8'h07, 8'h09, 1'b0);
      send(8'h05, 8'h05, 1'b0);
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_ready", op_ready, 1);
      chk("clr_hold_acc", acc_out, 24'h000001);
      send(8'h02, 8'h03, 1'b1);
      wait_result("clr", 24'h000006, 10'd1, 1'b0);
      @(negedge clk);
      chk("clr_valids", vcount - v0, 1);

      // Asynchronous reset in WAIT
      send(8'h09, 8'h09, 1'b1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_ready", op_ready, 0);
      chk("arst_start", mul_start, 0);
      chk("arst_valid", acc_valid, 0);
      chk("arst_acc", acc_out, 0);
      chk("arst_cnt", count_out, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_mulA", mul_A, 0);
      chk("arst_mulB", mul_B, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("rel_ready_low", op_ready, 0);
      @(negedge clk);
      chk("rel_ready_high", op_ready, 1);
      send(8'h03, 8'h04, 1'b1);
      wait_result("after_rst", 24'h00000C, 10'd1, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Operand sequencer and accumulator that sits around top_multiplier.
- Upstream side: accepts 8-bit operand pairs over a valid/ready handshake, drives the multiplier's start/in_A/in_B, and samples pp after a fixed latency.
- Downstream side: accumulates the products over a frame terminated by op_last, then presents the frame sum, product count and a sticky overflow flag.
- Serves as the control stage that turns the bare multiplier into a dot-product / MAC unit.

Parameters:
WIDTH, 8, operand width (multiplier in_A/in_B width); product width is 2*WIDTH
ACC_W, 24, accumulator width; must be greater than 2*WIDTH
MUL_LATENCY, 10, cycles from the mul_start cycle to the cycle in which mul_pp is valid; must be at least 2
COUNT_W, 10, width of the per-frame product counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
op_valid  input  1  operand pair valid
op_ready  output  1  block can accept an operand pair
op_A  input  WIDTH  operand A
op_B  input  WIDTH  operand B
op_last  input  1  pair is the final pair of its frame
clear  input  1  synchronous abort and clear, active-high
mul_start  output  1  start pulse to the multiplier
mul_A  output  WIDTH  multiplier operand A
mul_B  output  WIDTH  multiplier operand B
mul_pp  input  2*WIDTH  multiplier product
acc_out  output  ACC_W  frame sum; held until the next frame completes
count_out  output  COUNT_W  number of products in the completed frame
acc_valid  output  1  one-cycle pulse when acc_out/count_out update
overflow  output  1  sticky: an accumulator carry-out occurred in the reported frame

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - acc, count, acc_out, count_out, mul_A and mul_B go to 0.
  - op_ready, mul_start, acc_valid and overflow go to 0.
  - op_ready rises in the first cycle after reset is released.
- FSM states: IDLE, ISSUE, WAIT, ACCUM, DONE.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready at a clock edge: latch op_A into mul_A, op_B into mul_B, and op_last into the last flag; go to ISSUE.
  - op_ready is registered and is 0 in every state except IDLE.
- ISSUE:
  - mul_start=1 for exactly this one cycle.
  - Load wait counter with MUL_LATENCY-2; go to WAIT.
- WAIT:
  - Decrement the wait counter each cycle.
  - When the counter is 0, go to ACCUM.
  - The ACCUM cycle is exactly MUL_LATENCY cycles after the ISSUE cycle.
- mul_A and mul_B hold stable from ISSUE through ACCUM.
- ACCUM:
  - Sample mul_pp.
  - acc <= acc + zero-extended mul_pp, modulo 2^ACC_W.
  - On carry-out, set the internal overflow flag (sticky for the frame).
  - count <= count+1, wrapping at 2^COUNT_W.
  - If last=1 go to DONE, else go to IDLE.
- DONE:
  - acc_out <= acc, count_out <= count, overflow <= internal flag.
  - acc_valid=1 for this one cycle.
  - Clear acc, count and the internal flag to 0; go to IDLE.
- Outputs are registered and change only at DONE:
  - acc_out and count_out hold their value between frames.
  - overflow holds its value until the next DONE.
- Throughput: one pair per MUL_LATENCY+2 cycles (IDLE, ISSUE, WAIT×(MUL_LATENCY-1), ACCUM), plus one DONE cycle per frame.
- clear=1 at a clock edge, in any state:
  - state goes to IDLE; acc, count and the internal flag go to 0; mul_start goes to 0.
  - The in-flight product is discarded.
  - acc_out, count_out and overflow are not modified.
  - clear has priority over the handshake: no pair is accepted in a cycle where clear=1.
- op_valid high while the block is busy: op_ready=0, so no capture takes place. The upstream holds the pair until op_ready=1.
- Reset released mid-frame: the partial sum is lost and no acc_valid is produced.

Test Plan:
- Single-pair frame, pair (0x0A,0x20), last=1, mul_pp=0x0140 in the ACCUM cycle:
  - mul_start pulses once; acc_valid pulses MUL_LATENCY+1 cycles after the ISSUE cycle.
  - Result: acc_out=0x000140, count_out=1, overflow=0.
- Three-pair frame (0x0A,0x20), (0xFF,0xFF), (0x03,0x05) with products 0x0140, 0xFE01, 0x000F:
  - Result: acc_out=0x00FF50, count_out=3, overflow=0.
  - Exactly one acc_valid pulse for the frame.
- Overflow: 259 pairs of (0xFF,0xFF), each product 0xFE01:
  - Result: acc_out=0x00FB03, count_out=259, overflow=1.
  - The next frame of (0x01,0x01) reports acc_out=0x000001 and overflow=0.
- Handshake stall: op_valid held high with changing op_A/op_B while in WAIT:
  - op_ready=0 and mul_A/mul_B stay stable.
  - The next pair is captured only in IDLE; one pair is captured per handshake.
- clear asserted in WAIT of pair 2 of a frame:
  - FSM returns to IDLE and there is no acc_valid.
  - A following single pair (0x02,0x03), last=1, reports acc_out=0x000006 and count_out=1.
- reset asserted asynchronously in WAIT (between clock edges):
  - All outputs go to 0 immediately.
  - op_ready returns to 1 in the first cycle after release.
